// File: rtl/mux_rr_arb.sv
// N-channel registered select mux with valid/ready handshakes.
// The winning channel comes from a fixed select or a round-robin search.
module mux_rr_arb #(
    parameter int W    = 64,
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   out_chan
);

    logic [W-1:0]    data_q, data_d;
    logic [SELW-1:0] chan_q, chan_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            valid_q, valid_d;

    logic            load;
    logic            found;
    logic [SELW-1:0] win_idx;
    logic [W-1:0]    win_data;
    logic [N-1:0]    fixed_req;
    logic [N-1:0]    grant;

    // Pointer offset that wraps at N, so non-power-of-2 channel counts never
    // visit the unused indices.
    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) begin
            s = s - N;
        end
        return SELW'(s);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign fixed_req[gi] = in_valid[gi] && (sel == SELW'(gi));
            assign grant[gi]     = rst_n && load && found && (win_idx == SELW'(gi));
        end
    endgenerate

    always_comb begin
        load    = !valid_q || out_ready;
        found   = 1'b0;
        win_idx = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (fixed_req[i]) begin
                    found   = 1'b1;
                    win_idx = SELW'(i);
                end
            end
        end else begin
            // ptr itself is visited last (k == N).
            for (int k = 1; k <= N; k++) begin
                if (!found && in_valid[wrap_inc(ptr_q, k)]) begin
                    found   = 1'b1;
                    win_idx = wrap_inc(ptr_q, k);
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win_idx == SELW'(i)) begin
                win_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (|grant) begin
            data_d  = win_data;
            chan_d  = win_idx;
            valid_d = 1'b1;
            ptr_d   = win_idx;
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SELW'(N - 1);
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign in_ready  = grant;
    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench for mux_rr_arb: a 4x64 instance and a 3x16 instance.
module tb_mux_rr_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] in_data;
    logic [3:0]   in_valid, in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [63:0]  out_data;
    logic         out_valid, out_ready;
    logic [1:0]   out_chan;

    logic         rst3_n;
    logic [47:0]  in_data3;
    logic [2:0]   in_valid3, in_ready3;
    logic         mode3;
    logic [1:0]   sel3;
    logic [15:0]  out_data3;
    logic         out_valid3, out_ready3;
    logic [1:0]   out_chan3;

    typedef struct packed {
        logic [1:0]  chan;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_rr_arb #(.W(64), .N(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
    );

    mux_rr_arb #(.W(16), .N(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_chan(out_chan3)
    );

    function automatic logic [63:0] mkdata(input int i, input int tag);
        return {32'hDEAD_BEEF, 24'(tag), 8'(i)};
    endfunction

    function automatic logic [15:0] mk3(input int i);
        return 16'hA000 | 16'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic [3:0] v, input int tag);
        in_valid = v;
        for (int i = 0; i < 4; i++) begin
            in_data[i*64 +: 64] = mkdata(i, tag);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
        set_valid(4'hF, 0);
        rst_n = 1'b0;
        tick();
        total++;
        if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", in_ready); end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || out_chan !== 2'd0 || in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_state got v=%b d=%h c=%0d r=%b want v=0 d=0 c=0 r=0000",
                     out_valid, out_data, out_chan, in_ready);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b want=0001", in_ready); end
        exp_q.push_back('{chan: 2'd0, data: mkdata(0, 0)});
        tick();
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_chan !== e.chan || out_data !== e.data) begin
            bad++;
            $display("FAIL reset_first_word got c=%0d d=%h want c=%0d d=%h", out_chan, out_data, e.chan, e.data);
        end
        set_valid(4'h0, 0);
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_fixed();
        exp_t e;
        mode = 1'b0; sel = 2'd2;
        set_valid(4'hF, 0);
        #1;
        total++;
        if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_ready got=%b want=0100", in_ready); end
        exp_q.push_back('{chan: 2'd2, data: 64'hDEAD_BEEF_0000_0002});
        tick();
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_chan !== e.chan || out_data !== e.data) begin
            bad++;
            $display("FAIL fixed_word got c=%0d d=%h want c=%0d d=%h", out_chan, out_data, e.chan, e.data);
        end
        sel = 2'd3;
        set_valid(4'b0111, 1);
        #1;
        total++;
        if (in_ready !== 4'b0000) begin bad++; $display("FAIL fixed_nogrant_ready got=%b want=0000", in_ready); end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_chan !== 2'd2) begin
            bad++;
            $display("FAIL fixed_drain got v=%b c=%0d want v=0 c=2", out_valid, out_chan);
        end
    endtask

    task automatic test_rr_fair();
        exp_t e;
        int   seq[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mode = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            set_valid((c < 6) ? 4'hF : 4'b1101, c + 16);
            #1;
            total++;
            if (in_ready !== 4'(1 << seq[c])) begin
                bad++;
                $display("FAIL rr_ready c=%0d got=%b want=%b", c, in_ready, 4'(1 << seq[c]));
            end
            exp_q.push_back('{chan: 2'(seq[c]), data: mkdata(seq[c], c + 16)});
            tick();
            e = exp_q.pop_front();
            total++;
            if (out_valid !== 1'b1 || out_chan !== e.chan || out_data !== e.data) begin
                bad++;
                $display("FAIL rr_word c=%0d got c=%0d d=%h want c=%0d d=%h", c, out_chan, out_data, e.chan, e.data);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        exp_t held;
        set_valid(4'hF, 40);
        #1;
        total++;
        if (in_ready !== 4'b1000) begin bad++; $display("FAIL bp_first_ready got=%b want=1000", in_ready); end
        exp_q.push_back('{chan: 2'd3, data: mkdata(3, 40)});
        tick();
        held = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_chan !== held.chan || out_data !== held.data) begin
            bad++;
            $display("FAIL bp_first_word got c=%0d d=%h want c=%0d d=%h", out_chan, out_data, held.chan, held.data);
        end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_valid(4'hF, 41 + c);
            #1;
            total++;
            if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready c=%0d got=%b want=0000", c, in_ready); end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_chan !== held.chan || out_data !== held.data) begin
                bad++;
                $display("FAIL bp_hold c=%0d got v=%b c=%0d d=%h want v=1 c=%0d d=%h",
                         c, out_valid, out_chan, out_data, held.chan, held.data);
            end
        end
        out_ready = 1'b1;
        set_valid(4'hF, 50);
        #1;
        total++;
        if (in_ready !== 4'b0001) begin bad++; $display("FAIL bp_release_ready got=%b want=0001", in_ready); end
        exp_q.push_back('{chan: 2'd0, data: mkdata(0, 50)});
        tick();
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_chan !== e.chan || out_data !== e.data) begin
            bad++;
            $display("FAIL bp_refill got c=%0d d=%h want c=%0d d=%h", out_chan, out_data, e.chan, e.data);
        end
        set_valid(4'h0, 0);
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_mode_switch();
        exp_t e;
        mode = 1'b0; sel = 2'd3;
        set_valid(4'hF, 60);
        #1;
        total++;
        if (in_ready !== 4'b1000) begin bad++; $display("FAIL ms_fixed_ready got=%b want=1000", in_ready); end
        exp_q.push_back('{chan: 2'd3, data: mkdata(3, 60)});
        tick();
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_chan !== e.chan || out_data !== e.data) begin
            bad++;
            $display("FAIL ms_fixed_word got c=%0d d=%h want c=%0d d=%h", out_chan, out_data, e.chan, e.data);
        end
        mode = 1'b1;
        set_valid(4'hF, 61);
        #1;
        total++;
        if (in_ready !== 4'b0001) begin bad++; $display("FAIL ms_rr_ready got=%b want=0001", in_ready); end
        exp_q.push_back('{chan: 2'd0, data: mkdata(0, 61)});
        tick();
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_chan !== e.chan || out_data !== e.data) begin
            bad++;
            $display("FAIL ms_rr_word got c=%0d d=%h want c=%0d d=%h", out_chan, out_data, e.chan, e.data);
        end
        set_valid(4'h0, 0);
        tick();
    endtask

    task automatic test_non_pow2();
        exp_t e;
        int   seq[4] = '{0, 1, 2, 0};
        rst3_n = 1'b0; mode3 = 1'b1; sel3 = 2'd0; out_ready3 = 1'b1;
        in_valid3 = 3'b111;
        in_data3  = {mk3(2), mk3(1), mk3(0)};
        tick();
        tick();
        total++;
        if (out_valid3 !== 1'b0 || in_ready3 !== 3'b000) begin
            bad++;
            $display("FAIL np2_reset got v=%b r=%b want v=0 r=000", out_valid3, in_ready3);
        end
        rst3_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (in_ready3 !== 3'(1 << seq[c])) begin
                bad++;
                $display("FAIL np2_ready c=%0d got=%b want=%b", c, in_ready3, 3'(1 << seq[c]));
            end
            exp_q.push_back('{chan: 2'(seq[c]), data: 64'(mk3(seq[c]))});
            tick();
            e = exp_q.pop_front();
            total++;
            if (out_valid3 !== 1'b1 || out_chan3 !== e.chan || out_data3 !== e.data[15:0]) begin
                bad++;
                $display("FAIL np2_word c=%0d got c=%0d d=%h want c=%0d d=%h", c, out_chan3, out_data3, e.chan, e.data[15:0]);
            end
        end
        mode3 = 1'b0; sel3 = 2'd3;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (in_ready3 !== 3'b000) begin bad++; $display("FAIL np2_sel3_ready c=%0d got=%b want=000", c, in_ready3); end
            tick();
            total++;
            if (out_valid3 !== 1'b0) begin bad++; $display("FAIL np2_sel3_valid c=%0d got=%b want=0", c, out_valid3); end
        end
        mode3 = 1'b1;
        #1;
        total++;
        if (in_ready3 !== 3'b010) begin bad++; $display("FAIL np2_resume_ready got=%b want=010", in_ready3); end
        tick();
        total++;
        if (out_valid3 !== 1'b1 || out_chan3 !== 2'd1 || out_data3 !== mk3(1)) begin
            bad++;
            $display("FAIL np2_resume_word got v=%b c=%0d d=%h want v=1 c=1 d=%h", out_valid3, out_chan3, out_data3, mk3(1));
        end
        out_ready3 = 1'b0; rst3_n = 1'b0;
        #1;
        total++;
        if (in_ready3 !== 3'b000) begin bad++; $display("FAIL np2_midreset_ready got=%b want=000", in_ready3); end
        tick();
        total++;
        if (out_valid3 !== 1'b0) begin bad++; $display("FAIL np2_midreset_valid got=%b want=0", out_valid3); end
        rst3_n = 1'b1;
    endtask

    initial begin
        rst3_n = 1'b0; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
        in_valid3 = 3'b000; in_data3 = '0;
        test_reset();
        test_fixed();
        test_rr_fair();
        test_backpressure();
        test_mode_switch();
        test_non_pow2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench did not complete");
    end

endmodule
